// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: runs M x N output tiles with K accumulate passes each on one 32x32 systolic array.
// Define TILE_SCHED_TIMEOUT_EN to add a watchdog on the RUN/DRAIN handshake.
module matmul_tile_scheduler #(
    parameter int TILE            = 32,
    parameter int AWIDTH          = 10,
    parameter int CNT_W           = 4,
    parameter int PE_RESET_CYCLES = 2,
    parameter int TIMEOUT_W       = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_m_tiles,
    input  logic [CNT_W-1:0]  cfg_n_tiles,
    input  logic [CNT_W-1:0]  cfg_k_tiles,
    input  logic [AWIDTH-1:0] cfg_base_a,
    input  logic [AWIDTH-1:0] cfg_base_b,
    input  logic [AWIDTH-1:0] cfg_base_c,
    input  logic [AWIDTH-1:0] cfg_row_step_a,
    input  logic [AWIDTH-1:0] cfg_row_step_b,
    input  logic [AWIDTH-1:0] cfg_row_step_c,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              start_mat_mul,
    output logic              pe_reset,
    input  logic              done_mat_mul,
    output logic [AWIDTH-1:0] address_mat_a,
    output logic [AWIDTH-1:0] address_mat_b,
    output logic [AWIDTH-1:0] address_mat_c,
    output logic [CNT_W-1:0]  tile_m,
    output logic [CNT_W-1:0]  tile_n,
    output logic [CNT_W-1:0]  tile_k
);
    // state | meaning
    // IDLE  | waiting for cfg_start
    // CLEAR | pe_reset held to zero the PE accumulators
    // SETUP | tile addresses just registered
    // RUN   | start_mat_mul held until done_mat_mul
    // DRAIN | wait for done_mat_mul low, then advance indices
    // DONE  | job end; cfg_done pulses on the following cycle
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int CLR_W = (PE_RESET_CYCLES > 1) ? $clog2(PE_RESET_CYCLES) : 1;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_m_tiles, r_n_tiles, r_k_tiles;
    logic [CNT_W-1:0]  r_m, r_n, r_k;
    logic [CNT_W-1:0]  w_m_nxt, w_n_nxt, w_k_nxt;
    logic [AWIDTH-1:0] r_base_a, r_base_b, r_base_c;
    logic [AWIDTH-1:0] r_step_a, r_step_b, r_step_c;
    logic [AWIDTH-1:0] r_addr_a, r_addr_b, r_addr_c;
    logic [AWIDTH-1:0] w_addr_a, w_addr_b, w_addr_c;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic              r_done, r_err;
    logic              w_accept, w_zero_cnt, w_enter, w_tmo_hit, w_waiting;

    assign w_accept   = (r_state == S_IDLE) && cfg_start;
    assign w_zero_cnt = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
    assign w_enter    = (w_state_nxt != r_state);
    assign w_waiting  = (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef TILE_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '1;
        end else if (w_enter) begin
            r_tmo_cnt <= '1;
        end else if (w_waiting && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    assign w_tmo_hit = w_waiting && (r_tmo_cnt == '0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_W > 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_m_nxt     = '0;
                    w_n_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = w_zero_cnt ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == '0) w_state_nxt = S_SETUP;
            end
            S_SETUP: w_state_nxt = S_RUN;
            S_RUN: begin
                if (done_mat_mul)   w_state_nxt = S_DRAIN;
                else if (w_tmo_hit) w_state_nxt = S_DONE;
            end
            S_DRAIN: begin
                if (!done_mat_mul) begin
                    if (r_k != r_k_tiles - 1'b1) begin
                        w_k_nxt     = r_k + 1'b1;
                        w_state_nxt = S_SETUP;
                    end else if (r_n != r_n_tiles - 1'b1) begin
                        w_k_nxt     = '0;
                        w_n_nxt     = r_n + 1'b1;
                        w_state_nxt = S_CLEAR;
                    end else if (r_m != r_m_tiles - 1'b1) begin
                        w_k_nxt     = '0;
                        w_n_nxt     = '0;
                        w_m_nxt     = r_m + 1'b1;
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Addresses use the post-advance indices so they are valid in the first SETUP cycle.
    assign w_addr_a = r_base_a + AWIDTH'(w_m_nxt) * r_step_a + AWIDTH'(w_k_nxt) * AWIDTH'(TILE);
    assign w_addr_b = r_base_b + AWIDTH'(w_k_nxt) * r_step_b + AWIDTH'(w_n_nxt) * AWIDTH'(TILE);
    assign w_addr_c = r_base_c + AWIDTH'(w_m_nxt) * r_step_c + AWIDTH'(w_n_nxt) * AWIDTH'(TILE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_tiles <= '0;
            r_n_tiles <= '0;
            r_k_tiles <= '0;
            r_base_a  <= '0;
            r_base_b  <= '0;
            r_base_c  <= '0;
            r_step_a  <= '0;
            r_step_b  <= '0;
            r_step_c  <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_addr_c  <= '0;
            r_clr_cnt <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_m <= w_m_nxt;
            r_n <= w_n_nxt;
            r_k <= w_k_nxt;
            if (w_accept) begin
                r_m_tiles <= cfg_m_tiles;
                r_n_tiles <= cfg_n_tiles;
                r_k_tiles <= cfg_k_tiles;
                r_base_a  <= cfg_base_a;
                r_base_b  <= cfg_base_b;
                r_base_c  <= cfg_base_c;
                r_step_a  <= cfg_row_step_a;
                r_step_b  <= cfg_row_step_b;
                r_step_c  <= cfg_row_step_c;
            end
            if (w_enter && (w_state_nxt == S_SETUP)) begin
                r_addr_a <= w_addr_a;
                r_addr_b <= w_addr_b;
                r_addr_c <= w_addr_c;
            end
            if (w_enter) begin
                r_clr_cnt <= CLR_W'(PE_RESET_CYCLES - 1);
            end else if ((r_state == S_CLEAR) && (r_clr_cnt != '0)) begin
                r_clr_cnt <= r_clr_cnt - 1'b1;
            end
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_err <= w_zero_cnt;
            end else if (w_tmo_hit && (w_state_nxt == S_DONE)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cfg_busy      = (r_state != S_IDLE);
    assign cfg_done      = r_done;
    assign cfg_err       = r_err;
    assign start_mat_mul = (r_state == S_RUN);
    assign pe_reset      = (r_state == S_CLEAR);
    assign address_mat_a = r_addr_a;
    assign address_mat_b = r_addr_b;
    assign address_mat_c = r_addr_c;
    assign tile_m        = r_m;
    assign tile_n        = r_n;
    assign tile_k        = r_k;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: table and random jobs checked against a loop-nest model of the
// expected clear/pass sequence, plus hand sequences for start timing, zero count, abort and timeout.
`timescale 1ns/1ps
module tb_matmul_tile_scheduler;
    localparam int AW  = 10;
    localparam int CW  = 4;
    localparam int PRC = 2;
    localparam int TW  = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_start = 1'b0;
    logic [CW-1:0] cfg_m_tiles = '0, cfg_n_tiles = '0, cfg_k_tiles = '0;
    logic [AW-1:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
    logic [AW-1:0] cfg_row_step_a = '0, cfg_row_step_b = '0, cfg_row_step_c = '0;
    logic          cfg_busy, cfg_done, cfg_err, start_mat_mul, pe_reset;
    logic          done_mat_mul = 1'b0;
    logic [AW-1:0] address_mat_a, address_mat_b, address_mat_c;
    logic [CW-1:0] tile_m, tile_n, tile_k;

    always #5 clk = ~clk;

    matmul_tile_scheduler #(
        .TILE(32), .AWIDTH(AW), .CNT_W(CW), .PE_RESET_CYCLES(PRC), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_start(cfg_start),
        .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
        .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
        .cfg_row_step_a(cfg_row_step_a), .cfg_row_step_b(cfg_row_step_b),
        .cfg_row_step_c(cfg_row_step_c),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .start_mat_mul(start_mat_mul), .pe_reset(pe_reset), .done_mat_mul(done_mat_mul),
        .address_mat_a(address_mat_a), .address_mat_b(address_mat_b),
        .address_mat_c(address_mat_c),
        .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k)
    );

    typedef struct {
        int m, n, k;
        int ba, bb, bc, sa, sb, sc;
        int lat, hold, mid;
    } job_t;

    typedef struct {
        bit            clr;
        int            len;
        logic [AW-1:0] a, b, c;
    } ev_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Array model: done rises mdl_lat cycles after start is seen, falls mdl_hold cycles after start drops.
    int mdl_lat = 4, mdl_hold = 0;
    int mdl_ph = 0, mdl_cnt = 0, mdl_hcnt = 0;
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl_ph = 0;
            done_mat_mul = 1'b0;
        end else begin
            case (mdl_ph)
                0: if (start_mat_mul && mdl_lat >= 0) begin mdl_cnt = mdl_lat; mdl_ph = 1; end
                1: if (mdl_cnt <= 1) begin done_mat_mul = 1'b1; mdl_hcnt = mdl_hold; mdl_ph = 2; end
                   else mdl_cnt--;
                2: if (!start_mat_mul) begin
                       if (mdl_hcnt == 0) begin done_mat_mul = 1'b0; mdl_ph = 0; end
                       else mdl_hcnt--;
                   end
                default: mdl_ph = 0;
            endcase
        end
    end

    // Monitor: records pe_reset runs and pass starts (with addresses) in order.
    ev_t           obs_q[$];
    ev_t           exp_q[$];
    ev_t           mon_e;
    int            pe_run = 0, overlap = 0, done_pulses = 0, start_cyc = 0, addr_moves = 0;
    logic          prev_start = 1'b0;
    logic [AW-1:0] ra = '0, rb = '0, rc = '0;
    always @(negedge clk) begin
        if (start_mat_mul && pe_reset) overlap++;
        if (pe_reset) pe_run++;
        else if (pe_run != 0) begin
            mon_e.clr = 1'b1; mon_e.len = pe_run; mon_e.a = '0; mon_e.b = '0; mon_e.c = '0;
            obs_q.push_back(mon_e);
            pe_run = 0;
        end
        if (start_mat_mul) begin
            start_cyc++;
            if (!prev_start) begin
                mon_e.clr = 1'b0; mon_e.len = 0;
                mon_e.a = address_mat_a; mon_e.b = address_mat_b; mon_e.c = address_mat_c;
                obs_q.push_back(mon_e);
                ra = address_mat_a; rb = address_mat_b; rc = address_mat_c;
            end else if (address_mat_a != ra || address_mat_b != rb || address_mat_c != rc) begin
                addr_moves++;
            end
        end
        if (cfg_done) done_pulses++;
        prev_start = start_mat_mul;
    end

    // Reference: one clear per output tile, then K passes, loops m/n/k, addresses mod 2^AW.
    task automatic build_exp(input job_t j);
        ev_t e;
        exp_q.delete();
        if (j.m == 0 || j.n == 0 || j.k == 0) return;
        for (int m = 0; m < j.m; m++)
            for (int n = 0; n < j.n; n++) begin
                e.clr = 1'b1; e.len = PRC; e.a = '0; e.b = '0; e.c = '0;
                exp_q.push_back(e);
                for (int k = 0; k < j.k; k++) begin
                    e.clr = 1'b0; e.len = 0;
                    e.a = AW'((j.ba + m * j.sa + k * 32) % (1 << AW));
                    e.b = AW'((j.bb + k * j.sb + n * 32) % (1 << AW));
                    e.c = AW'((j.bc + m * j.sc + n * 32) % (1 << AW));
                    exp_q.push_back(e);
                end
            end
    endtask

    function automatic int pass_count();
        int c = 0;
        foreach (obs_q[i]) if (!obs_q[i].clr) c++;
        return c;
    endfunction

    task automatic drive_cfg(input job_t j);
        cfg_m_tiles = CW'(j.m); cfg_n_tiles = CW'(j.n); cfg_k_tiles = CW'(j.k);
        cfg_base_a = AW'(j.ba); cfg_base_b = AW'(j.bb); cfg_base_c = AW'(j.bc);
        cfg_row_step_a = AW'(j.sa); cfg_row_step_b = AW'(j.sb); cfg_row_step_c = AW'(j.sc);
    endtask

    task automatic clear_mon();
        obs_q.delete();
        overlap = 0; done_pulses = 0; addr_moves = 0; start_cyc = 0; pe_run = 0;
    endtask

    task automatic run_job(input job_t j, input string tag);
        bit seen = 0;
        bit exp_err;
        ev_t o, x;
        build_exp(j);
        exp_err = (j.m == 0 || j.n == 0 || j.k == 0);
        mdl_lat = j.lat; mdl_hold = j.hold;
        @(negedge clk);
        clear_mon();
        drive_cfg(j);
        cfg_start = 1'b1;
        for (int g = 0; g < 20000 && !seen; g++) begin
            @(negedge clk);
            if (cfg_done) begin
                seen = 1;
                cfg_start = 1'b0;
            end else if (j.mid != 0 && g == j.mid) begin
                cfg_m_tiles = 3; cfg_n_tiles = 1; cfg_k_tiles = 1;
                cfg_base_a = 'h155; cfg_base_b = 'h2AA; cfg_row_step_c = 'h11;
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " err"}, 64'(cfg_err), 64'(exp_err));
        check({tag, " busy_at_done"}, 64'(cfg_busy), 64'd0);
        @(negedge clk);
        check({tag, " done_pulses"}, 64'(done_pulses), 64'd1);
        check({tag, " n_events"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            o = obs_q[i]; x = exp_q[i];
            check($sformatf("%s ev%0d {clr,len,a,b,c}", tag, i),
                  64'({o.clr, o.len[7:0], o.a, o.b, o.c}),
                  64'({x.clr, x.len[7:0], x.a, x.b, x.c}));
        end
        check({tag, " start_pe_overlap"}, 64'(overlap), 64'd0);
        check({tag, " addr_stable"}, 64'(addr_moves), 64'd0);
    endtask

    job_t tbl[8];
    job_t rj;
    bit   ok;

    initial begin
        tbl[0] = '{1, 1, 1, 'h10, 'h20, 'h30, 0, 0, 0, 40, 0, 0};
        tbl[1] = '{2, 2, 2, 0, 0, 0, 'h40, 'h40, 'h40, 5, 1, 0};
        tbl[2] = '{3, 2, 1, 'h3F0, 'h3E0, 'h3FF, 'h200, 'h300, 'h1F1, 2, 0, 0};
        tbl[3] = '{1, 1, 0, 'h10, 'h20, 'h30, 1, 1, 1, 3, 0, 0};
        tbl[4] = '{1, 3, 3, 'h7, 'h9, 'hB, 'h33, 'h55, 'h77, 1, 2, 0};
        tbl[5] = '{2, 2, 2, 0, 0, 0, 'h40, 'h40, 'h40, 3, 0, 12};
        tbl[6] = '{1, 1, 15, 'h100, 0, 0, 0, 'h20, 0, 1, 0, 0};
        tbl[7] = '{0, 2, 2, 'h1, 'h2, 'h3, 'h4, 'h5, 'h6, 2, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy/done/err/start/pe", 64'({cfg_busy, cfg_done, cfg_err, start_mat_mul, pe_reset}), 64'd0);
        check("rst addresses", 64'({address_mat_a, address_mat_b, address_mat_c}), 64'd0);
        check("rst tiles", 64'({tile_m, tile_n, tile_k}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post-rst busy", 64'(cfg_busy), 64'd0);

        // Start-to-array timing
        mdl_lat = 3; mdl_hold = 0;
        drive_cfg(tbl[0]);
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        check("t+1 busy,pe_reset,start", 64'({cfg_busy, pe_reset, start_mat_mul}), 64'b110);
        @(negedge clk);
        check("t+2 pe_reset", 64'(pe_reset), 64'd1);
        @(negedge clk);
        check("t+3 pe_reset,start", 64'({pe_reset, start_mat_mul}), 64'b00);
        check("t+3 addresses", 64'({address_mat_a, address_mat_b, address_mat_c}),
              64'({10'h10, 10'h20, 10'h30}));
        @(negedge clk);
        check("t+4 start", 64'(start_mat_mul), 64'd1);
        ok = 0;
        for (int g = 0; g < 200 && !ok; g++) begin @(negedge clk); if (cfg_done) ok = 1; end
        check("timing job done", 64'(ok), 64'd1);
        check("timing job err", 64'(cfg_err), 64'd0);

        // Zero count: done and err at t+2, no array activity
        @(negedge clk);
        clear_mon();
        drive_cfg(tbl[3]);
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        check("zero t+1 busy,done", 64'({cfg_busy, cfg_done}), 64'b10);
        @(negedge clk);
        check("zero t+2 done,err", 64'({cfg_done, cfg_err}), 64'b11);
        @(negedge clk);
        check("zero no activity", 64'(start_cyc + obs_q.size()), 64'd0);

        // Table jobs
        foreach (tbl[i]) run_job(tbl[i], $sformatf("tbl%0d", i));

        // Random jobs
        for (int r = 0; r < 8; r++) begin
            rj.m = $urandom_range(1, 3); rj.n = $urandom_range(1, 3); rj.k = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) rj.n = 0;
            rj.ba = $urandom_range(0, 1023); rj.bb = $urandom_range(0, 1023); rj.bc = $urandom_range(0, 1023);
            rj.sa = $urandom_range(0, 1023); rj.sb = $urandom_range(0, 1023); rj.sc = $urandom_range(0, 1023);
            rj.lat = $urandom_range(1, 8); rj.hold = $urandom_range(0, 3); rj.mid = 0;
            run_job(rj, $sformatf("rnd%0d", r));
        end

        // Reset during RUN of pass 3 aborts with no done; a fresh job then runs fully
        mdl_lat = 10; mdl_hold = 0;
        @(negedge clk);
        clear_mon();
        drive_cfg(tbl[1]);
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        ok = 0;
        for (int g = 0; g < 500 && !ok; g++) begin @(negedge clk); if (pass_count() >= 3) ok = 1; end
        check("abort reached pass 3", 64'(ok), 64'd1);
        check("abort in RUN", 64'(start_mat_mul), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("abort outputs async 0",
              64'({cfg_busy, cfg_done, cfg_err, start_mat_mul, pe_reset, tile_m, tile_n, tile_k}), 64'd0);
        check("abort addresses async 0", 64'({address_mat_a, address_mat_b, address_mat_c}), 64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("abort no done pulse", 64'(done_pulses), 64'd0);
        run_job(tbl[1], "after_abort");

`ifdef TILE_SCHED_TIMEOUT_EN
        // Watchdog: array never answers
        mdl_lat = -1;
        @(negedge clk);
        clear_mon();
        drive_cfg(tbl[0]);
        cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        ok = 0;
        for (int g = 0; g < 500 && !ok; g++) begin @(negedge clk); if (cfg_done) ok = 1; end
        check("timeout done", 64'(ok), 64'd1);
        check("timeout err,start", 64'({cfg_err, start_mat_mul}), 64'b10);
        @(negedge clk);
        check("timeout run cycles", 64'(start_cyc), 64'd64);
        mdl_lat = 4;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
